// File: rtl/uart_rx_param_if.sv
// rtl/uart_rx_param_if.sv - serial line and received-byte bus between pad and host FIFO
interface uart_rx_param_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  rx_in;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  data_valid;
   logic                  parity_err;
   logic                  frame_err;
   logic                  busy;

   modport master (
      input  rx_in,
      output data_out, data_valid, parity_err, frame_err, busy
   );

   modport slave (
      output rx_in,
      input  data_out, data_valid, parity_err, frame_err, busy
   );
endinterface

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised oversampling UART receiver
// Optional 2-of-3 majority bit decisions: define UART_RX_MAJORITY_VOTE_EN.
module uart_rx_param #(
   parameter int DATA_WIDTH  = 8,
   parameter int PARITY_MODE = 1,
   parameter int STOP_BITS   = 1,
   parameter int OVERSAMPLE  = 16,
   parameter int MSB_FIRST   = 1
) (
   input  logic              clk_baud_sample,
   input  logic              rst,
   uart_rx_param_if.master   bus
);
   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] MID_START = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] MID_BIT   = CW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE, S_BREAK
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            sync_q;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [3:0]            bit_idx_q, bit_idx_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  par_bit_q, par_bit_d;
   logic                  ferr_q, ferr_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  data_valid_q, data_valid_d;
   logic                  parity_err_q, parity_err_d;
   logic                  frame_err_q, frame_err_d;
   logic                  rx_s, bit_val, at_mid, exp_par, par_bad, fe_now;

   assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_VOTE_EN
   // hist_q[0] holds rx_s at mid-1, hist_q[1] at mid-2 when cnt reaches mid
   logic [1:0] hist_q;
   always_ff @(posedge clk_baud_sample or negedge rst) begin
      if (!rst) hist_q <= 2'b11;
      else      hist_q <= {hist_q[0], rx_s};
   end
   assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
   assign bit_val = rx_s;
`endif

   assign at_mid  = (cnt_q == ((state_q == S_START) ? MID_START : MID_BIT));
   assign exp_par = (PARITY_MODE == 2) ? ~(^shift_q) : ^shift_q;
   assign par_bad = (PARITY_MODE != 0) && (par_bit_q != exp_par);
   assign fe_now  = ferr_q | ~bit_val;

   always_ff @(posedge clk_baud_sample or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         sync_q       <= 2'b11;
         cnt_q        <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         par_bit_q    <= 1'b0;
         ferr_q       <= 1'b0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync_q       <= {sync_q[0], bus.rx_in};
         cnt_q        <= cnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         par_bit_q    <= par_bit_d;
         ferr_q       <= ferr_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q + CW'(1);
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      par_bit_d    = par_bit_q;
      ferr_d       = ferr_q;
      data_out_d   = data_out_q;
      data_valid_d = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = S_START;
         end
         S_START: begin
            if (at_mid) begin
               if (bit_val) begin
                  state_d = S_IDLE;
               end else begin
                  state_d   = S_DATA;
                  cnt_d     = '0;
                  bit_idx_d = '0;
                  ferr_d    = 1'b0;
               end
            end
         end
         S_DATA: begin
            if (at_mid) begin
               if (MSB_FIRST != 0) shift_d = {shift_q[DATA_WIDTH-2:0], bit_val};
               else                shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
               bit_idx_d = bit_idx_q + 4'd1;
               if (bit_idx_q == 4'(DATA_WIDTH - 1)) begin
                  bit_idx_d = '0;
                  state_d   = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
               end
            end
         end
         S_PARITY: begin
            if (at_mid) begin
               par_bit_d = bit_val;
               state_d   = S_STOP;
            end
         end
         S_STOP: begin
            if (at_mid) begin
               ferr_d    = fe_now;
               bit_idx_d = bit_idx_q + 4'd1;
               // Results are registered so they are visible exactly while in DONE
               if (bit_idx_q == 4'(STOP_BITS - 1)) begin
                  state_d      = S_DONE;
                  frame_err_d  = fe_now;
                  parity_err_d = par_bad;
                  if (!fe_now && !par_bad) begin
                     data_valid_d = 1'b1;
                     data_out_d   = shift_q;
                  end
               end
            end
         end
         S_DONE: begin
            cnt_d   = '0;
            state_d = rx_s ? S_IDLE : S_BREAK;
         end
         S_BREAK: begin
            cnt_d = '0;
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.data_out   = data_out_q;
   assign bus.data_valid = data_valid_q;
   assign bus.parity_err = parity_err_q;
   assign bus.frame_err  = frame_err_q;
   assign bus.busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - scoreboard bench for default and 7-bit/odd/2-stop/x8 receivers
module tb_uart_rx_param;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      logic [2:0] flags;   // {frame_err, parity_err, data_valid}
      logic [8:0] data;
      int         cyc;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];
   exp_t e1, e2;

   uart_rx_param_if #(.DATA_WIDTH(8)) b1();
   uart_rx_param_if #(.DATA_WIDTH(7)) b2();

   uart_rx_param #(
      .DATA_WIDTH(8), .PARITY_MODE(1), .STOP_BITS(1), .OVERSAMPLE(16), .MSB_FIRST(1)
   ) dut1 (
      .clk_baud_sample(clk), .rst(rst), .bus(b1)
   );

   uart_rx_param #(
      .DATA_WIDTH(7), .PARITY_MODE(2), .STOP_BITS(2), .OVERSAMPLE(8), .MSB_FIRST(0)
   ) dut2 (
      .clk_baud_sample(clk), .rst(rst), .bus(b2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: bench did not finish, checks=%0d", checks);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (b1.data_valid || b1.parity_err || b1.frame_err) begin
         if (q1.size() == 0) begin
            chk("unexpected_pulse_dut1", {b1.frame_err, b1.parity_err, b1.data_valid}, 3'b000);
         end else begin
            e1 = q1.pop_front();
            chk("flags_dut1", {b1.frame_err, b1.parity_err, b1.data_valid}, e1.flags);
            chk("data_dut1", b1.data_out, e1.data[7:0]);
            chk("latency_dut1", cyc, e1.cyc);
         end
      end
   end

   always @(negedge clk) begin
      if (b2.data_valid || b2.parity_err || b2.frame_err) begin
         if (q2.size() == 0) begin
            chk("unexpected_pulse_dut2", {b2.frame_err, b2.parity_err, b2.data_valid}, 3'b000);
         end else begin
            e2 = q2.pop_front();
            chk("flags_dut2", {b2.frame_err, b2.parity_err, b2.data_valid}, e2.flags);
            chk("data_dut2", b2.data_out, e2.data[6:0]);
            chk("latency_dut2", cyc, e2.cyc);
         end
      end
   end

   function automatic logic [15:0] mk8(input logic [7:0] d, input logic p, input logic s);
      logic [15:0] f;
      f = '1;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[1+i] = d[7-i];
      f[9]  = p;
      f[10] = s;
      return f;
   endfunction

   function automatic logic [15:0] mk7(input logic [6:0] d, input logic p, input logic s1, input logic s2);
      logic [15:0] f;
      f = '1;
      f[0] = 1'b0;
      for (int i = 0; i < 7; i++) f[1+i] = d[i];
      f[8]  = p;
      f[9]  = s1;
      f[10] = s2;
      return f;
   endfunction

   task automatic line(input int sel, input logic v);
      if (sel == 0) b1.rx_in = v;
      else          b2.rx_in = v;
   endtask

   task automatic hold(input int sel, input logic v, input int n);
      line(sel, v);
      repeat (n) @(negedge clk);
   endtask

   // Starts at a negedge; the start bit is captured on the following posedge
   task automatic send(input int sel, input logic [15:0] bits, input int n, input int glitch,
                       input bit has_exp, input logic [2:0] flags, input logic [8:0] data);
      int   os;
      int   lat;
      exp_t e;
      logic b;
      os  = (sel == 0) ? 16 : 8;
      lat = (sel == 0) ? 170 : 86;
      @(negedge clk);
      if (has_exp) begin
         e.flags = flags;
         e.data  = data;
         e.cyc   = cyc + 1 + lat;
         if (sel == 0) q1.push_back(e);
         else          q2.push_back(e);
      end
      for (int j = 0; j < n * os; j++) begin
         if (j > 0) @(negedge clk);
         b = bits[j / os];
         if (j == glitch) b = ~b;
         line(sel, b);
      end
      @(negedge clk);
   endtask

   initial begin
      int busy_cnt;
      b1.rx_in = 1'b1;
      b2.rx_in = 1'b1;
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("reset_data_out", b1.data_out, 8'h00);
      chk("reset_pulses", {b1.frame_err, b1.parity_err, b1.data_valid}, 3'b000);
      chk("reset_busy", b1.busy, 1'b0);
      chk("reset_dut2", {b2.data_out, b2.busy, b2.data_valid}, 9'h000);
      rst = 1'b1;
      hold(0, 1'b1, 20);

      send(0, mk8(8'hA5, 1'b0, 1'b1), 11, -1, 1'b1, 3'b001, 9'h0A5);
      hold(0, 1'b1, 32);
      send(0, mk8(8'hA5, 1'b1, 1'b1), 11, -1, 1'b1, 3'b010, 9'h0A5);
      hold(0, 1'b1, 32);

      busy_cnt = 0;
      line(0, 1'b0);
      for (int k = 1; k <= 24; k++) begin
         @(negedge clk);
         if (k == 4) line(0, 1'b1);
         busy_cnt += int'(b1.busy);
      end
      chk("false_start_busy_cycles", busy_cnt, 8);
      chk("false_start_idle", b1.busy, 1'b0);
      hold(0, 1'b1, 16);

      send(0, mk8(8'h00, 1'b0, 1'b0), 11, -1, 1'b1, 3'b100, 9'h0A5);
      hold(0, 1'b0, 40);
      chk("break_busy", b1.busy, 1'b1);
      hold(0, 1'b0, 8);
      hold(0, 1'b1, 32);
      chk("break_recovered", b1.busy, 1'b0);
      send(0, mk8(8'h3C, 1'b0, 1'b1), 11, -1, 1'b1, 3'b001, 9'h03C);
      hold(0, 1'b1, 32);

`ifdef UART_RX_MAJORITY_VOTE_EN
      send(0, mk8(8'hA5, 1'b0, 1'b1), 11, 24, 1'b1, 3'b001, 9'h0A5);
`else
      send(0, mk8(8'hA5, 1'b0, 1'b1), 11, 24, 1'b1, 3'b010, 9'h03C);
`endif
      hold(0, 1'b1, 32);

      send(0, mk8(8'h5A, 1'b0, 1'b1), 5, -1, 1'b0, 3'b000, 9'h000);
      hold(0, 1'b1, 8);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_mid_data_out", b1.data_out, 8'h00);
      chk("rst_mid_pulses", {b1.frame_err, b1.parity_err, b1.data_valid}, 3'b000);
      chk("rst_mid_busy", b1.busy, 1'b0);
      line(0, 1'b1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      hold(0, 1'b1, 32);
      send(0, mk8(8'h81, 1'b0, 1'b1), 11, -1, 1'b1, 3'b001, 9'h081);
      hold(0, 1'b1, 32);

      send(1, mk7(7'h55, 1'b1, 1'b1, 1'b1), 11, -1, 1'b1, 3'b001, 9'h055);
      hold(1, 1'b1, 32);
      send(1, mk7(7'h12, 1'b1, 1'b1, 1'b0), 11, -1, 1'b1, 3'b100, 9'h055);
      hold(1, 1'b1, 32);

      repeat (20) @(negedge clk);
      chk("pending_dut1", q1.size(), 0);
      chk("pending_dut2", q2.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver, successor to the fixed 8-bit dual-clock receiver. Runs on a single oversampling clock. Data width, parity mode, stop-bit count, oversampling ratio and bit order are configurable. Reports framing and parity errors and validates the start bit. It sits between the pad-side serial line and the byte bus feeding the host FIFO.

## Interface

Parameters:

- DATA_WIDTH, 8: data bits per frame, legal range 5–9.
- PARITY_MODE, 1: 0 = none, 1 = even (parity bit = ^data), 2 = odd (parity bit = ~^data).
- STOP_BITS, 1: number of stop bits, 1 or 2.
- OVERSAMPLE, 16: samples per bit, a power of two in the range 8–64.
- MSB_FIRST, 1: 1 = first received data bit lands in data_out[DATA_WIDTH-1]; 0 = LSB first.

Ports (clock and reset first):

- clk_baud_sample, in, 1: oversampling clock at OVERSAMPLE × baud rate; the only clock.
- rst, in, 1: asynchronous, active-low reset.
- rx_in, in, 1: serial line, idle high, asynchronous to clk_baud_sample.
- data_out, out, DATA_WIDTH: last good frame; holds its value until the next good frame.
- data_valid, out, 1: one-cycle pulse when data_out is updated.
- parity_err, out, 1: one-cycle pulse, parity mismatch.
- frame_err, out, 1: one-cycle pulse, a stop bit was sampled low.
- busy, out, 1: high in every state except IDLE.

## Operation

Input path:
- rx_in passes through a 2-flop synchronizer; rx_s is the second flop.
- All decisions use rx_s only.

Counters:
- cnt: log2(OVERSAMPLE)-bit sample counter.
- bit_idx: counts received data bits.

State machine:
- IDLE
  - rx_s == 0 → START, cnt = 0.
- START
  - cnt increments each cycle.
  - At cnt == OVERSAMPLE/2-1 (mid start bit): rx_s == 1 → IDLE (false start, no flags); rx_s == 0 → DATA, cnt = 0, bit_idx = 0.
- DATA
  - Sample at cnt == OVERSAMPLE-1; cnt wraps to 0.
  - Shift the sample into the shift register per MSB_FIRST.
  - After DATA_WIDTH samples → PARITY if PARITY_MODE != 0, else STOP.
- PARITY
  - One sample at cnt == OVERSAMPLE-1; store it; → STOP.
- STOP
  - STOP_BITS samples, each at cnt == OVERSAMPLE-1.
  - Any low stop sample sets a sticky frame-error flag for the frame.
  - After the last stop sample → DONE.
- DONE (single cycle)
  - Frame error → frame_err = 1; data_out unchanged.
  - Parity mismatch → parity_err = 1; data_out unchanged.
  - Both conditions → both flags pulse.
  - Clean frame → data_out = shift register, data_valid = 1.
  - Next state: rx_s == 1 → IDLE; rx_s == 0 (break / stuck-low line) → BREAK.
- BREAK
  - Wait for rx_s == 1 → IDLE.
  - No further flags; a continuous low line produces exactly one frame_err.

Other rules:
- Unused high data bits: none; data_out is exactly DATA_WIDTH bits.
- Reset mid-frame: the FSM returns to IDLE immediately; the partial frame is discarded with no pulse.

## Timing

Reset values:
- data_out = 0.
- data_valid, parity_err, frame_err, busy = 0.
- Synchronizer flops = 1.
- FSM = IDLE, cnt = 0.

Latency:
- Flags and data_valid assert exactly L = 2 + OVERSAMPLE/2 + OVERSAMPLE×(DATA_WIDTH + P + STOP_BITS) clk_baud_sample rising edges after the edge on which the rx_in low level is first captured. P = 1 if parity is enabled, else 0.
- Default configuration: L = 2 + 8 + 16×10 = 170.

Pulse and status rules:
- All pulses last exactly one cycle and are mutually exclusive with data_valid.
- busy rises one cycle after rx_s goes low and falls on entry to IDLE.
- Back-to-back frames: a start bit immediately after the last stop sample is accepted. DONE → IDLE → START costs at most 2 cycles, well within the OVERSAMPLE/2 margin.

## Configuration

- UART_RX_MAJORITY_VOTE_EN defined:
  - Every bit decision (start validation, data, parity, stop) is the 2-of-3 majority of rx_s at cnt = mid-2, mid-1 and mid.
  - mid is OVERSAMPLE/2-1 for the start bit and OVERSAMPLE-1 for all other bits.
  - Latency is unchanged.
- Undefined: a single sample at mid.
- Directed test: a one-cycle glitch at mid-bit must be rejected only when the macro is defined.

## Test plan

- Default configuration, send 0xA5 with even parity bit 0 and stop 1 → data_valid pulses at L = 170, data_out = 0xA5, no error flags.
- Same frame with the parity bit flipped to 1 → parity_err pulses at L = 170; data_valid stays 0; data_out keeps its previous value.
- Low pulse of 4 sample clocks on an idle line → FSM returns to IDLE; no pulses; busy high for about 8 cycles.
- Stop bit driven 0, then the line held low for 3 bit times → a single frame_err pulse; FSM in BREAK; recovers on the line going high; the next 0x3C frame is received correctly.
- DATA_WIDTH=7, PARITY_MODE=2, STOP_BITS=2, MSB_FIRST=0, OVERSAMPLE=8: send 0x55 LSB first, odd parity 1 → data_out = 0x55, L = 2 + 4 + 8×10 = 86.
- rst asserted mid-data-bit 4, released, then 0x81 sent → no pulse from the aborted frame; 0x81 is received cleanly; all outputs read 0 while rst is low.
